// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, signed/unsigned per operation,
// start/busy/done handshake with a held product register.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  booth_mult_seq_if.slave  bus
);

  // One extra bit lets unsigned operands share the signed recurrence
  localparam int unsigned IW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     a_q, a_d;
  logic [IW-1:0]     q_q, q_d;
  logic [IW-1:0]     m_q, m_d;
  logic              q1_q, q1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IW-1:0]     m_ext_c;
  logic [IW-1:0]     q_ext_c;
  logic [IW-1:0]     sum_c;

  // Operand extension for the load action
  always_comb begin
    m_ext_c = {1'b0, bus.multiplicand};
    q_ext_c = {1'b0, bus.multiplier};
    if (bus.signed_mode) begin
      m_ext_c = {bus.multiplicand[WIDTH-1], bus.multiplicand};
      q_ext_c = {bus.multiplier[WIDTH-1], bus.multiplier};
    end
  end

  // Booth add/subtract selected by {Q[0], Q_1}
  always_comb begin
    sum_c = a_q;
    case ({q_q[0], q1_q})
      2'b01:   sum_c = a_q + m_q;
      2'b10:   sum_c = a_q + ~m_q + IW'(1);
      default: sum_c = a_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          a_d     = '0;
          q_d     = q_ext_c;
          m_d     = m_ext_c;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Arithmetic right shift of {sum, Q, Q_1}
        a_d   = {sum_c[IW-1], sum_c[IW-1:1]};
        q_d   = {sum_c[0], q_q[IW-1:1]};
        q1_d  = q_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(IW - 1)) begin
          state_d   = S_DONE;
          product_d = {a_d[WIDTH-2:0], q_d};
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier; successor to the team's fixed 4-bit Booth unit.
- Adds generic operand width and a per-operation signed/unsigned mode.
- Adds a start/busy/done handshake with a held product register and an asynchronous reset.
- Sits as a shared multi-cycle arithmetic unit beside the datapath; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override).

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE or DONE.
- signed_mode, input, 1, 1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand, input, WIDTH, operand M; sampled with start.
- multiplier, input, WIDTH, operand Q; sampled with start.
- product, output, 2*WIDTH, result register; held until the next accepted start completes.
- busy, output, 1, high while iterating.
- done, output, 1, one-cycle pulse when product becomes valid.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, product=0, busy=0, done=0, internal A/Q/M/Q_1/counter=0. Deasserting rst_n takes effect at the next clk edge.
- Internal width IW = WIDTH+1.
  - Operands are extended to IW bits: sign-extended if signed_mode=1, zero-extended if 0.
  - This lets unsigned operands use the same signed Booth recurrence.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1: load A=0, Q=ext(multiplier), M=ext(multiplicand), Q_1=0, counter=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1): one Booth step per clock, selected by {Q[0],Q_1}.
  - 01: A = A + M.
  - 10: A = A - M, computed as A + ~M + 1, all IW bits.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Q_1} by one, sign bit = MSB of the new A.
  - Then counter increments.
  - After exactly IW steps, go to DONE and write the low 2*WIDTH bits of {A,Q} into product.
  - These bits are exact for both modes, since the full result fits in 2*WIDTH bits.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in this cycle is accepted: same load action as IDLE, go to RUN. This is back-to-back operation.
  - Otherwise go to IDLE.
- Latency: start accepted at edge N. busy is high for edges N+1..N+IW. product is valid and done=1 in the cycle following edge N+IW.
  - Total: IW+1 cycles from start to done; WIDTH=8 gives 10 cycles.
- start while in RUN: ignored; operands and signed_mode are not resampled; the current operation is unaffected.
- product changes only on the RUN→DONE transition; it holds its value through IDLE and the next RUN.
- Reset mid-RUN: operation aborted and all outputs return to reset values immediately. No done pulse is produced for the aborted operation.
- Corner operands:
  - M = most-negative value in signed mode: the subtraction must not overflow. This is guaranteed by the IW-bit internal width.
  - Zero operands: product=0 after full latency; there is no early termination.
- No combinational path from inputs to outputs; all outputs are registered or decoded from the state register.

Test Plan:
- WIDTH=8, signed_mode=1, M=-3 (0xFD), Q=5, start one cycle → busy high 9 cycles, done one pulse at cycle 10, product=0xFFF1 (-15), held after.
- signed_mode=1, M=0x80, Q=0x80 (-128 × -128) → product=0x4000. Then signed_mode=0, M=0xFF, Q=0xFF → product=0xFE01 (65025).
- Unsigned M=0xFF, Q=0x02 → 0x01FE. Signed same operands → 0xFFFE (-2). Checks that the mode changes the result.
- Start M=7, Q=6; re-pulse start with M=1, Q=1 mid-RUN → ignored, product=0x002A at the normal done time.
- Back-to-back: start asserted during the DONE cycle with M=2, Q=3 → immediate RUN, second done exactly 10 cycles later, product=0x0006. The first product (previous operation) is held until then.
- Assert rst_n=0 at RUN step 4 (asynchronous, between edges) → busy, done and product go to 0 without waiting for clk, no done pulse. A new start after release completes normally.
